// File: rtl/synth_pkg.sv
// Shared types, widths and waveform lookup for the polyphonic synth.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int SAMPLE_W = 11;
    localparam int AUDIO_W  = 12;
    localparam int PITCH_W  = 12;
    localparam int LEVEL_W  = 8;
    localparam int PHASE_W  = 6;

    // 0 square, 1 saw, 2 triangle, 3 25% pulse; one period is 64 phase steps.
    function automatic logic [SAMPLE_W-1:0] wave_sample(input logic [PHASE_W-1:0] phase,
                                                        input logic [1:0] sel);
        case (sel)
            2'd0:    return phase[5] ? '0 : '1;
            2'd1:    return {phase, 5'b0};
            2'd2:    return phase[5] ? {~phase[4:0], 6'b0} : {phase[4:0], 6'b0};
            default: return (phase[5:4] == 2'b00) ? '1 : '0;
        endcase
    endfunction

endpackage

// File: rtl/audio_pwm_generator.sv
// Free-running sawtooth compare PWM for the amplifier input.
module audio_pwm_generator
    import synth_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [AUDIO_W-1:0] audio,
    output logic               pwm
);

    logic [AUDIO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else if (ena) begin
            cnt <= cnt + 1'b1;
            pwm <= (cnt < audio);
        end
    end

endmodule

// File: rtl/bus_debouncer.sv
// Per-bit debouncer: two-flop synchroniser, then a bit only follows its input
// once the synchronised value has differed from it for DEBOUNCE_CYCLES clocks.
module bus_debouncer #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]         sync1, sync2;
    logic [WIDTH-1:0][CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            dout  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == dout[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    dout[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/channel.sv
// Single tone generator: phase advances once every `pitch` clocks while enabled.
module channel
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [PITCH_W-1:0]  pitch,
    input  logic [1:0]          waveform,
    output logic [SAMPLE_W-1:0] sample
);

    logic [PITCH_W-1:0] div_cnt;
    logic [PHASE_W-1:0] phase;

    // Disabled voices restart at phase 0 so a fresh note always begins identically.
    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (div_cnt == pitch - 1'b1) begin
            div_cnt <= '0;
            phase   <= phase + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sample = ena ? wave_sample(phase, waveform) : '0;

endmodule

// File: rtl/voice_envelope.sv
// Attack/sustain/release amplitude envelope for one voice, stepped on ramp ticks.
module voice_envelope
    import synth_pkg::*;
#(
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key,
    input  logic               tick,
    output logic [LEVEL_W-1:0] level,
    output logic               active
);

    localparam logic [LEVEL_W:0]   A_STEP    = (LEVEL_W + 1)'(ATTACK_STEP);
    localparam logic [LEVEL_W-1:0] R_STEP    = LEVEL_W'(RELEASE_STEP);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    env_state_t state;

    // Key changes win over ticks; a tick coinciding with a transition is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            level  <= '0;
            active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    level <= '0;
                    if (key) begin
                        state  <= ATTACK;
                        active <= 1'b1;
                    end
                end
                ATTACK: begin
                    if (!key) begin
                        state <= RELEASE;
                    end else if (tick) begin
                        if ({1'b0, level} + A_STEP >= {1'b0, LEVEL_MAX}) begin
                            level <= LEVEL_MAX;
                            state <= SUSTAIN;
                        end else begin
                            level <= level + A_STEP[LEVEL_W-1:0];
                        end
                    end
                end
                SUSTAIN: begin
                    level <= LEVEL_MAX;
                    if (!key) state <= RELEASE;
                end
                RELEASE: begin
                    // Re-press resumes the attack from the current level.
                    if (key) begin
                        state <= ATTACK;
                    end else if (tick) begin
                        if (level <= R_STEP) begin
                            level  <= '0;
                            state  <= IDLE;
                            active <= 1'b0;
                        end else begin
                            level <= level - R_STEP;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    level  <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/poly_synth_core.sv
// N-voice synth: debounced note keys, per-voice envelopes, two-stage
// registered mixer feeding the PWM amp driver.
module poly_synth_core
    import synth_pkg::*;
#(
    parameter int                          NUM_CHANNELS    = 4,
    parameter logic [NUM_CHANNELS*12-1:0]  PITCH_TABLE     = {12'd44, 12'd89, 12'd119, 12'd178},
    parameter int                          RAMP_DIV        = 4096,
    parameter int                          ATTACK_STEP     = 8,
    parameter int                          RELEASE_STEP    = 4,
    parameter int                          DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] buttons,
    input  logic                    waveform_mode,
    output logic                    pwm_out,
    output logic                    shutdown_b,
    output logic                    gain,
    output logic [NUM_CHANNELS-1:0] voices_active,
    output logic [1:0]              waveform_sel
);

    localparam int LOG2N     = $clog2(NUM_CHANNELS);
    localparam int SUM_W     = SAMPLE_W + LOG2N;
    localparam int MIX_SHIFT = LOG2N - 1;
    localparam int PROD_W    = SAMPLE_W + LEVEL_W;
    localparam int TW        = $clog2(RAMP_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);

    logic [NUM_CHANNELS:0]                   deb;
    logic                                    wave_prev;
    logic [TW-1:0]                           tick_cnt;
    logic                                    tick;
    logic [NUM_CHANNELS-1:0][LEVEL_W-1:0]    levels;
    logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0]   ch_out;
    logic [NUM_CHANNELS-1:0][SAMPLE_W-1:0]   scaled;
    logic [SUM_W-1:0]                        mix_sum;
    logic [AUDIO_W-1:0]                      audio;

    assign shutdown_b = 1'b1;
    assign gain       = 1'b1;

    bus_debouncer #(
        .WIDTH           (NUM_CHANNELS + 1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  ({waveform_mode, buttons}),
        .dout (deb)
    );

    // Waveform advances once per debounced press, wrapping 3 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wave_prev    <= 1'b0;
            waveform_sel <= '0;
        end else begin
            wave_prev <= deb[NUM_CHANNELS];
            if (deb[NUM_CHANNELS] && !wave_prev) waveform_sel <= waveform_sel + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                        tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_voice
        voice_envelope #(
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_env (
            .clk    (clk),
            .rst    (rst),
            .key    (deb[g]),
            .tick   (tick),
            .level  (levels[g]),
            .active (voices_active[g])
        );

        channel u_chan (
            .clk      (clk),
            .rst      (rst),
            .ena      (voices_active[g]),
            .pitch    (PITCH_TABLE[12*g +: 12]),
            .waveform (waveform_sel),
            .sample   (ch_out[g])
        );
    end

    // Stage 1: scale each voice by its envelope level (unity is 256, so 255 is just under).
    always_ff @(posedge clk) begin
        if (rst) begin
            scaled <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                scaled[i] <= SAMPLE_W'((PROD_W'(ch_out[i]) * PROD_W'(levels[i])) >> LEVEL_W);
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) mix_sum = mix_sum + SUM_W'(scaled[i]);
    end

    // Stage 2: the sum is one bit wider than AUDIO_W needs per doubling, so the
    // shift keeps full scale at 12 bits without any chance of overflow.
    always_ff @(posedge clk) begin
        if (rst) audio <= '0;
        else     audio <= AUDIO_W'(mix_sum >> MIX_SHIFT);
    end

    audio_pwm_generator u_pwm (
        .clk   (clk),
        .rst   (rst),
        .ena   (1'b1),
        .audio (audio),
        .pwm   (pwm_out)
    );

endmodule

// File: doc/poly_synth_core.md
Name: poly_synth_core

Overview:
Parametrised N-voice successor to the two-channel synth top. It debounces NUM_CHANNELS note buttons plus one waveform button and maps each note button to a fixed pitch from a parameter table. Each voice gets an attack/sustain/release amplitude envelope to remove clicks, and all scaled voices are mixed in a registered N-way adder. The mix drives audio_pwm_generator and the PmodAMP2 control pins. It instantiates the existing bus_debouncer, channel and audio_pwm_generator blocks and replaces wave_adder.

Parameters:
NUM_CHANNELS, 4, number of voices; power of two, 2..8
PITCH_TABLE, {12'd44,12'd89,12'd119,12'd178}, packed NUM_CHANNELS*12 bits; voice i pitch = bits [12*i+11:12*i] (default: v0=C3 178, v1=G3 119, v2=C4 89, v3=C5 44)
RAMP_DIV, 4096, clocks per envelope tick; >=2
ATTACK_STEP, 8, level increment per tick, 1..255
RELEASE_STEP, 4, level decrement per tick, 1..255

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
buttons  in  NUM_CHANNELS  raw note buttons, bit i = voice i
waveform_mode  in  1  raw waveform-cycle button
pwm_out  out  1  PWM audio to amp
shutdown_b  out  1  amp enable, constant 1
gain  out  1  amp gain select, constant 1 (6 dB)
voices_active  out  NUM_CHANNELS  bit i = 1 while voice i envelope is not IDLE
waveform_sel  out  2  current waveform code

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); every register clears on the clk edge where rst=1.
- Reset values: voices_active=0, waveform_sel=0, all envelope levels=0, all states=IDLE, mixer and audio registers=0, tick counter=0. shutdown_b=1 and gain=1 always, including during reset.
- Debounce: one bus_debouncer of width NUM_CHANNELS+1 covers {waveform_mode, buttons}.
- Waveform select:
  - A rising edge of the debounced waveform bit (registered previous value, reset 0) increments waveform_sel; 3 wraps to 0.
  - One increment per press; a held button does not repeat.
  - waveform_sel drives every channel.waveform.
- Tick counter:
  - Counts 0..RAMP_DIV-1 and wraps.
  - tick=1 for exactly the one cycle when the counter equals RAMP_DIV-1.
- Envelope, per voice, 8-bit level; states IDLE, ATTACK, SUSTAIN, RELEASE:
  - IDLE: level=0. Debounced key=1 moves to ATTACK on the next cycle.
  - ATTACK: on each tick, level=min(level+ATTACK_STEP,255). Move to SUSTAIN in the same cycle the level reaches 255. Key=0 moves to RELEASE (takes priority over tick-driven transitions).
  - SUSTAIN: level holds at 255. Key=0 moves to RELEASE.
  - RELEASE: on each tick, level=max(level-RELEASE_STEP,0). Move to IDLE in the cycle the level reaches 0. Key=1 moves to ATTACK and continues from the current level, with no reset to 0.
  - Key and tick in the same cycle: the transition is taken first and the tick applies from the next tick onward.
- Channel enable: channel.ena = (state != IDLE). channel.pitch comes from PITCH_TABLE, constant.
- Mixer stage 1 (registered): scaled_i = (channel_out_i[10:0] * level_i) >> 8, 11-bit unsigned.
- Mixer stage 2 (registered): sum = sum of all scaled_i, width 11+log2(NUM_CHANNELS). audio = sum >> (log2(NUM_CHANNELS)-1), 12 bits; NUM_CHANNELS=2 gives no shift. Overflow is impossible by construction.
- Latency: channel output to audio register is 2 cycles. The audio_pwm_generator has ena=1.
- Reset mid-note: voice returns to IDLE with level 0 on the following cycle and ignores the held key until rst=0. An already-held key then re-attacks from 0.
- All voices IDLE: audio=0 after 2 cycles.

Decomposition:
- synth_pkg holds:
  - env_state_t enum {IDLE, ATTACK, SUSTAIN, RELEASE}
  - SAMPLE_W=11, AUDIO_W=12, PITCH_W=12, LEVEL_W=8
- Sub-module voice_envelope (inputs clk, rst, key, tick; outputs level[7:0], active) holds one state machine. It is instantiated NUM_CHANNELS times in a generate loop alongside channel.

Test Plan:
1. Reset with buttons=4'b1111 held -> voices_active=0, waveform_sel=0, audio=0, shutdown_b=1, gain=1. After rst drops and debounce completes, all four voices go ATTACK.
2. RAMP_DIV=4, ATTACK_STEP=64, press voice 0 -> level 64,128,192,255 on ticks 1-4; SUSTAIN entered on tick 4; voices_active=4'b0001.
3. From SUSTAIN, RELEASE_STEP=100, release voice 0 -> level 155,55,0 on ticks 1-3; IDLE on tick 3; voices_active=0; channel ena low.
4. Re-press during RELEASE at level 55, ATTACK_STEP=64 -> next levels 119,183,247,255, with no dip to 0.
5. Waveform button pressed 5 times with clean gaps -> waveform_sel 1,2,3,0,1. A 10000-cycle hold produces a single increment.
6. Force all channel outputs=2047, all levels=255, NUM_CHANNELS=4 -> scaled=2039, audio=(4*2039)>>1=4078, exactly 2 cycles after the forced input.
